// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one req/gnt/rvalid memory bus between the
// fetch (i_*) and load/store (d_*) ports, one transaction in flight.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   enable                     permits new grants
//   i_req/i_addr               fetch request; i_gnt comb accept
//   i_rvalid/i_rdata/i_err     fetch response (one-cycle strobe)
//   d_req/d_we/d_be/d_addr/d_wdata  data request; d_gnt comb accept
//   d_rvalid/d_rdata/d_err     data response (one-cycle strobe)
//   m_req/m_we/m_be/m_addr/m_wdata  registered memory request
//   m_gnt/m_rvalid/m_rdata     memory accept and response
//
// Optional: define RV32_ARB_TIMEOUT_EN to add a response timeout that
// returns an error strobe after TIMEOUT_CYCLES in REQ/WAIT. Without it
// the arbiter waits forever and i_err/d_err are tied 0.

module rv32_mem_arbiter #(
  parameter int AW             = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [1:0] state;
  logic       owner;
  logic [3:0] streak;
  logic       arb_ok;
  logic       at_max;
  logic       d_win;
  logic       i_win;
  logic       tmo;
  logic       done;

  // Grants are gated by reset so every output reads 0 while it is held.
  always_comb begin
    arb_ok = !reset && enable && (state == S_IDLE);
    at_max = (streak == STREAK_MAX);
    d_win  = arb_ok && d_req && !(i_req && at_max);
    i_win  = arb_ok && i_req && !d_win;
  end

  assign i_gnt = i_win;
  assign d_gnt = d_win;

`ifdef RV32_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          i_err_q;
  logic          d_err_q;

  // tcnt sits at 0 in IDLE, so it reads 0 on the first REQ cycle.
  assign tmo = (state != S_IDLE) &&
               (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == S_IDLE) begin
      tcnt <= '0;
    end else if (!tmo) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      i_err_q <= tmo && !owner;
      d_err_q <= tmo && owner;
    end
  end

  assign i_err = i_err_q;
  assign d_err = d_err_q;
`else
  assign tmo   = (TIMEOUT_CYCLES < 0);
  assign i_err = 1'b0;
  assign d_err = 1'b0;
`endif

  // A timeout overrides any m_gnt/m_rvalid seen in the same cycle.
  assign done = ((state == S_WAIT) && m_rvalid) || tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= 1'b0;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_win || d_win) begin
            state   <= S_REQ;
            owner   <= d_win;
            m_req   <= 1'b1;
            m_we    <= d_win && d_we;
            m_be    <= d_win ? d_be : 4'hF;
            m_addr  <= d_win ? d_addr : i_addr;
            m_wdata <= d_win ? d_wdata : '0;
            if (d_win && i_req) begin
              streak <= at_max ? streak : streak + 4'd1;
            end else begin
              streak <= '0;
            end
          end
        end
        S_REQ: begin
          if (tmo) begin
            m_req <= 1'b0;
            state <= S_IDLE;
          end else if (m_gnt) begin
            m_req <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= done && !owner;
      d_rvalid <= done && owner;
      if (done && !owner) begin
        i_rdata <= tmo ? '0 : m_rdata;
      end
      if (done && owner) begin
        d_rdata <= tmo ? '0 : m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed and randomized checks of the arbiter
// against a transaction-level model kept in the bench.

module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;

  rv32_mem_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Transaction model: busy = a transaction owns the bus,
  // acc = memory has accepted it and a response is awaited.
  bit          busy, owner, acc;
  int          streak;
  logic        e_mwe;
  logic [3:0]  e_mbe;
  logic [31:0] e_maddr, e_mwdata;
  bit          e_irv, e_drv;
  logic [31:0] e_ird, e_drd;
  bit          last_gi, last_gd;

  logic        o_ig, o_dg, o_mreq, o_mwe, o_irv, o_drv;
  logic [3:0]  o_mbe;
  logic [31:0] o_maddr, o_mwdata, o_ird, o_drd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic model_reset();
    busy = 0; owner = 0; acc = 0; streak = 0;
    e_mwe = 0; e_mbe = '0; e_maddr = '0; e_mwdata = '0;
    e_irv = 0; e_drv = 0; e_ird = '0; e_drd = '0;
    last_gi = 0; last_gd = 0;
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    bit gi, gd, n_irv, n_drv;
    @(negedge clk);
    gd = !busy && enable && d_req && !(i_req && streak == 4);
    gi = !busy && enable && i_req && !gd;
    o_ig = i_gnt; o_dg = d_gnt; o_mreq = m_req; o_mwe = m_we;
    o_mbe = m_be; o_maddr = m_addr; o_mwdata = m_wdata;
    o_irv = i_rvalid; o_drv = d_rvalid; o_ird = i_rdata;
    o_drd = d_rdata;
    chk("i_gnt", i_gnt, gi);
    chk("d_gnt", d_gnt, gd);
    chk("m_req", m_req, busy && !acc);
    chk("m_we", m_we, e_mwe);
    chk("m_be", m_be, e_mbe);
    chk("m_addr", m_addr, e_maddr);
    chk("m_wdata", m_wdata, e_mwdata);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    chk("i_err", i_err, 0);
    chk("d_err", d_err, 0);
    n_irv = 0; n_drv = 0;
    if (gi || gd) begin
      busy = 1; owner = gd; acc = 0;
      e_mwe = gd ? d_we : 1'b0;
      e_mbe = gd ? d_be : 4'hF;
      e_maddr = gd ? d_addr : i_addr;
      e_mwdata = gd ? d_wdata : 32'h0;
      if (gd && i_req) streak = (streak < 4) ? streak + 1 : 4;
      else streak = 0;
    end else if (busy && !acc && m_gnt) begin
      acc = 1;
    end else if (busy && acc && m_rvalid) begin
      busy = 0;
      if (owner) begin n_drv = 1; e_drd = m_rdata; end
      else begin n_irv = 1; e_ird = m_rdata; end
    end
    last_gi = gi; last_gd = gd;
    @(posedge clk);
    #1;
    e_irv = n_irv; e_drv = n_drv;
  endtask

  task automatic auto_mem(bit rnd);
    if (rnd) begin
      m_gnt = busy && !acc && ($urandom % 3 != 0);
      m_rvalid = (busy && acc) ? ($urandom % 2 == 0)
                               : ($urandom % 8 == 0);
    end else begin
      m_gnt = busy && !acc;
      m_rvalid = busy && acc;
    end
    m_rdata = $urandom;
  endtask

  task automatic retire();
    if (last_gi) i_req = 0;
    if (last_gd) d_req = 0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      if (!busy && !e_irv && !e_drv && !i_req && !d_req) break;
      retire();
      auto_mem(0);
      step();
    end
    chk("drain_bound", k < 40, 1);
    m_gnt = 0; m_rvalid = 0;
  endtask

  initial begin
    logic [9:0] seq;
    int ng, mr, gn;
    model_reset();
    // Reset with requests pending: everything must read 0.
    #1 reset = 1;
    enable = 1; i_req = 1; d_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rdata", d_rdata, 0);
    i_req = 0; d_req = 0;
    @(posedge clk); #1 reset = 0;
    model_reset();

    // Fetch only.
    i_req = 1; i_addr = 32'h100;
    step();
    chk("f_gnt0", o_ig, 1);
    i_req = 0; m_gnt = 1;
    step();
    chk("f_maddr1", o_maddr, 32'h100);
    chk("f_mbe1", o_mbe, 4'hF);
    chk("f_mreq1", o_mreq, 1);
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF;
    step();
    m_rvalid = 0;
    step();
    chk("f_rvalid3", o_irv, 1);
    chk("f_rdata3", o_ird, 32'hDEADBEEF);
    chk("f_drv3", o_drv, 0);

    // Simultaneous requests: D first, I granted with d_rvalid.
    i_req = 1; d_req = 1; d_we = 1; d_addr = 32'h200;
    d_wdata = 32'h12345678; d_be = 4'b0011;
    step();
    chk("s_dgnt", o_dg, 1);
    chk("s_ignt0", o_ig, 0);
    d_req = 0; m_gnt = 1;
    step();
    chk("s_mwe", o_mwe, 1);
    chk("s_maddr", o_maddr, 32'h200);
    chk("s_mwdata", o_mwdata, 32'h12345678);
    chk("s_mbe", o_mbe, 4'b0011);
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0BADF00D;
    step();
    m_rvalid = 0;
    step();
    chk("s_drv", o_drv, 1);
    chk("s_ignt", o_ig, 1);
    i_req = 0;
    drain();

    // Starvation bound: both held high.
    i_req = 1; d_req = 1; d_we = 0; seq = '0; ng = 0;
    for (int k = 0; k < 100 && ng < 10; k++) begin
      auto_mem(0);
      step();
      if (last_gi || last_gd) begin
        seq = {seq[8:0], last_gd};
        ng++;
      end
    end
    chk("starve_order", seq, 10'b1111011110);
    chk("starve_streak", streak, 0);
    i_req = 0; d_req = 0;
    drain();

    // Stall with enable dropped in REQ.
    d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
    step();
    chk("e_dgnt", o_dg, 1);
    d_req = 0; enable = 0; i_req = 1; i_addr = 32'h400;
    mr = 0; gn = 0;
    repeat (5) begin
      step();
      mr += int'(o_mreq);
      gn += int'(o_ig) + int'(o_dg);
    end
    chk("e_mreq_hold", mr, 5);
    chk("e_no_gnt", gn, 0);
    m_gnt = 1;
    step();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'h55AA55AA;
    step();
    m_rvalid = 0;
    step();
    chk("e_drv", o_drv, 1);
    chk("e_drd", o_drd, 32'h55AA55AA);
    chk("e_ignt_off", o_ig, 0);
    enable = 1;
    step();
    chk("e_ignt_on", o_ig, 1);
    i_req = 0;
    drain();

    // Reset while waiting for the response.
    i_req = 1; i_addr = 32'h500;
    step();
    i_req = 0; m_gnt = 1;
    step();
    m_gnt = 0;
    #2 reset = 1;
    #1;
    chk("r_maddr", m_addr, 0);
    chk("r_mbe", m_be, 0);
    chk("r_mreq", m_req, 0);
    chk("r_irv", i_rvalid, 0);
    m_rvalid = 1; m_rdata = 32'h77777777;
    @(posedge clk); #1 reset = 0;
    model_reset();
    step();
    m_rvalid = 0;
    step();
    chk("r_no_irv", o_irv, 0);
    i_req = 1; i_addr = 32'h600;
    step();
    i_req = 0; m_gnt = 1;
    step();
    m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D;
    step();
    m_rvalid = 0;
    step();
    chk("r_irv_after", o_irv, 1);
    chk("r_ird_after", o_ird, 32'hCAFEF00D);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      retire();
      enable = ($urandom % 10 != 0);
      if (!i_req && ($urandom % 2 == 0)) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && ($urandom % 2 == 0)) begin
        d_req = 1; d_we = $urandom; d_be = $urandom;
        d_addr = $urandom; d_wdata = $urandom;
      end
      auto_mem(1);
      step();
    end
    retire();
    enable = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-ported memory bus between the priRV32 instruction-fetch port (I) and load/store port (D).
- Sits between the core and memory. Allows one outstanding transaction at a time.
- Data access has priority, with a bounded-starvation guarantee for fetch.
- The memory side uses a req/gnt request phase followed by an rvalid response phase.

Parameters:
- AW, 32, address width in bits.
- MAX_D_STREAK, 4, number of consecutive D grants allowed while i_req is pending before I is forced to win; legal range 1..15.
- TIMEOUT_CYCLES, 64, used only with the optional feature; cycles from m_req assertion to forced error response.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new grants; in-flight transactions always complete.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch accepted (combinational).
- i_rvalid  out  1  one-cycle fetch response strobe.
- i_rdata  out  32  fetch data.
- i_err  out  1  fetch error, qualified by i_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write.
- d_be  in  4  byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  32  write data.
- d_gnt  out  1  data accepted (combinational).
- d_rvalid  out  1  one-cycle data response strobe; also sent for writes.
- d_rdata  out  32  load data.
- d_err  out  1  data error, qualified by d_rvalid.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write, registered.
- m_be  out  4  memory byte enables, registered.
- m_addr  out  AW  memory address, registered.
- m_wdata  out  32  memory write data, registered.
- m_gnt  in  1  memory accepted request.
- m_rvalid  in  1  memory response.
- m_rdata  in  32  memory read data.

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0, state = IDLE, streak counter = 0.
  - Reset mid-transaction abandons the transaction; no x_rvalid is produced.
- States: IDLE, REQ, WAIT. A registered owner bit (0 = I, 1 = D) records which port holds the bus.
- IDLE:
  - Arbitration occurs only when enable=1.
  - Winner is D if d_req, unless i_req=1 and streak==MAX_D_STREAK; otherwise I if i_req.
  - The winner's gnt is asserted combinationally in that cycle.
  - On the clock edge: m_* are loaded from the winner's fields (I: we=0, be=4'hF, wdata=0), m_req<=1, owner is set, state -> REQ.
  - With enable=0 or no request: both gnt=0, state stays IDLE.
- Streak counter:
  - Increments on a D grant while i_req=1, saturating at MAX_D_STREAK.
  - Clears on an I grant, or on a D grant with i_req=0.
- REQ: hold m_* stable. On m_gnt=1: m_req<=0, state -> WAIT.
- WAIT: on m_rvalid=1, in the next cycle the owner's x_rvalid=1 for exactly one cycle with x_rdata=m_rdata, x_err=0; state -> IDLE.
- m_rvalid in IDLE or REQ is ignored.
- Throughput:
  - Minimum one transaction per 3 cycles: gnt @0, m_req @1 (m_gnt @1), WAIT @2 (m_rvalid @2), x_rvalid @3.
  - A new grant is possible in the same cycle as x_rvalid.
- Non-owner rvalid/err stay 0. x_rdata holds its last value between strobes.
- enable falling in REQ/WAIT does not abort; the transaction finishes normally.

Optional Feature:
- Macro: RV32_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ/WAIT, starting at 0 on entry to REQ.
  - On reaching TIMEOUT_CYCLES: m_req<=0; the owner gets x_rvalid=1, x_err=1, x_rdata=0 for one cycle; state -> IDLE.
  - m_gnt/m_rvalid on that same cycle are ignored; the error response wins.
- Undefined: no counter; the arbiter waits indefinitely; i_err and d_err are tied 0.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100; memory grants immediately, returns 0xDEADBEEF one cycle later -> i_gnt @0, m_addr=0x100/m_be=F @1, i_rvalid=1 with i_rdata=0xDEADBEEF @3, d_rvalid stays 0.
- Simultaneous requests: i_req=d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678, d_be=4'b0011 -> d_gnt first, m_we=1 with those fields; i_gnt on the cycle of d_rvalid.
- Starvation: d_req and i_req held high, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D…; streak returns to 0 after the I grant.
- Stall/enable: m_gnt delayed 5 cycles with enable dropped in REQ -> m_* stable for all 5 cycles, transaction completes, no new gnt while enable=0.
- Reset mid-WAIT: assert reset between m_gnt and m_rvalid -> all outputs 0 immediately (asynchronously), no x_rvalid afterwards, next request served normally.
- With RV32_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never grants -> d_rvalid=1, d_err=1, d_rdata=0 after the 8-cycle timeout; m_req drops.
